cheat_engine: RTL and testbench

//  Multi-slot CPU read-override engine for cheat codes. Each slot matches a full 16-bit CPU address,

---
 rtl/cheat_engine_if.sv | 21 ++
 rtl/cheat_engine.sv | 152 +++++++++++++++
 tb/tb_cheat_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cheat_engine_if.sv
// Bus bundle for the cheat engine: PiBus config port and the CPU read-side signals it snoops.
interface cheat_engine_if;
    logic        pi_ce_cc;
    logic        pi_we;
    logic        pi_act;
    logic [7:0]  pi_addr;
    logic [7:0]  pi_wdata;
    logic [15:0] cpu_addr;
    logic        cpu_m2;
    logic        cpu_rw;

    modport master (
        output pi_ce_cc, pi_we, pi_act, pi_addr, pi_wdata,
        output cpu_addr, cpu_m2, cpu_rw
    );

    modport slave (
        input pi_ce_cc, pi_we, pi_act, pi_addr, pi_wdata,
        input cpu_addr, cpu_m2, cpu_rw
    );
endinterface

// File: rtl/cheat_engine.sv
// Multi-slot CPU read-override engine: full-address match, masked data compare, hit counting,
// auto-disable after a hit limit, and a per-read latched replacement byte.
module cheat_engine #(
    parameter int SLOTS  = 32,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cheat_engine_if.slave        bus,
    input  logic                 cheats_on_i,
    input  logic [7:0]           prg_do_i,
    output logic [7:0]           cc_do_o,
    output logic                 cc_ce_o,
    output logic [7:0]           pi_do_o
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  cmp;
        logic [7:0]  repl;
        logic [7:0]  mask;
        logic        en;
        logic        cmp_en;
        logic [7:0]  limit;
        logic [7:0]  hits;
    } slot_t;

    slot_t             slot_q [SLOTS];
    slot_t             slot_d [SLOTS];
    logic              rd_st_q;
    logic              hold_q, hold_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        hold_do_q, hold_do_d;
    logic [7:0]        pi_do_q, pi_do_d;

    logic              rd;
    logic [SLOTS-1:0]  match;
    logic              found;
    logic [IDX_W-1:0]  win;
    logic              sample;
    logic              pi_valid;
    logic              pi_wr;
    logic [IDX_W-1:0]  pi_idx;
    logic [2:0]        pi_reg;
    logic [8:0]        hits_inc;

    assign rd       = bus.cpu_m2 & bus.cpu_rw;
    assign pi_valid = 32'(bus.pi_addr[7:3]) < 32'(SLOTS);
    assign pi_idx   = bus.pi_addr[3 +: IDX_W];
    assign pi_reg   = bus.pi_addr[2:0];
    assign pi_wr    = bus.pi_ce_cc & bus.pi_we & bus.pi_act & pi_valid;
    assign sample   = rd_st_q && (cnt_q == 4'(SETTLE - 1)) && cheats_on_i;

    // Lowest-index matching slot wins; the descending scan leaves it as the last assignment.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            match[i] = slot_q[i].en && (bus.cpu_addr == slot_q[i].addr) &&
                       (!slot_q[i].cmp_en ||
                        (((prg_do_i ^ slot_q[i].cmp) & slot_q[i].mask) == 8'h00));
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        hold_do_d = hold_do_q;
        slot_d    = slot_q;
        pi_do_d   = 8'h00;
        hits_inc  = {1'b0, slot_q[win].hits} + 9'd1;

        if (!rd_st_q) begin
            cnt_d  = 4'd0;
            hold_d = 1'b0;
        end else if (cnt_q != 4'(SETTLE)) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (sample && found) begin
            hold_d    = 1'b1;
            hold_do_d = slot_q[win].repl;
            if (slot_q[win].hits != 8'hFF)
                slot_d[win].hits = slot_q[win].hits + 8'd1;
            if (slot_q[win].limit != 8'h00 && hits_inc >= {1'b0, slot_q[win].limit})
                slot_d[win].en = 1'b0;
        end

        // Applied after the hit update so a config write on the sample edge takes precedence.
        if (pi_wr) begin
            case (pi_reg)
                3'd0: slot_d[pi_idx].addr[7:0]  = bus.pi_wdata;
                3'd1: slot_d[pi_idx].addr[15:8] = bus.pi_wdata;
                3'd2: slot_d[pi_idx].cmp        = bus.pi_wdata;
                3'd3: slot_d[pi_idx].repl       = bus.pi_wdata;
                3'd4: slot_d[pi_idx].mask       = bus.pi_wdata;
                3'd5: begin
                    slot_d[pi_idx].en     = bus.pi_wdata[0];
                    slot_d[pi_idx].cmp_en = bus.pi_wdata[1];
                end
                3'd6: slot_d[pi_idx].limit      = bus.pi_wdata;
                default: slot_d[pi_idx].hits    = 8'h00;
            endcase
        end

        if (bus.pi_ce_cc && pi_valid) begin
            case (pi_reg)
                3'd0: pi_do_d = slot_q[pi_idx].addr[7:0];
                3'd1: pi_do_d = slot_q[pi_idx].addr[15:8];
                3'd2: pi_do_d = slot_q[pi_idx].cmp;
                3'd3: pi_do_d = slot_q[pi_idx].repl;
                3'd4: pi_do_d = slot_q[pi_idx].mask;
                3'd5: pi_do_d = {6'b0, slot_q[pi_idx].cmp_en, slot_q[pi_idx].en};
                3'd6: pi_do_d = slot_q[pi_idx].limit;
                default: pi_do_d = slot_q[pi_idx].hits;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot table is plain flops, not a RAM, so it is cleared like any register.
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
            rd_st_q   <= 1'b0;
            cnt_q     <= 4'd0;
            hold_q    <= 1'b0;
            hold_do_q <= 8'h00;
            pi_do_q   <= 8'h00;
        end else begin
            slot_q    <= slot_d;
            rd_st_q   <= rd;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            hold_do_q <= hold_do_d;
            pi_do_q   <= pi_do_d;
        end
    end

    assign cc_ce_o = hold_q & cheats_on_i & bus.cpu_m2 & bus.cpu_rw;
    assign cc_do_o = cc_ce_o ? hold_do_q : 8'h00;
    assign pi_do_o = pi_do_q;

endmodule

// File: tb/tb_cheat_engine.sv
// Directed bench for cheat_engine: match/compare, priority, limits, saturation, races and reset.
module tb_cheat_engine;
    localparam int SLOTS  = 8;
    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cheats_on;
    logic [7:0] prg_do;
    logic [7:0] cc_do;
    logic       cc_ce;
    logic [7:0] pi_do;
    int         errors = 0;
    int         checks = 0;

    cheat_engine_if bus ();

    cheat_engine #(.SLOTS(SLOTS), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cheats_on_i(cheats_on),
        .prg_do_i   (prg_do),
        .cc_do_o    (cc_do),
        .cc_ce_o    (cc_ce),
        .pi_do_o    (pi_do)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pi_drive(input int slot, input int r, input logic [7:0] d);
        bus.pi_addr  = 8'((slot << 3) | r);
        bus.pi_wdata = d;
        bus.pi_ce_cc = 1'b1;
        bus.pi_act   = 1'b1;
        bus.pi_we    = 1'b1;
    endtask

    task automatic pi_idle();
        bus.pi_ce_cc = 1'b0;
        bus.pi_act   = 1'b0;
        bus.pi_we    = 1'b0;
    endtask

    task automatic pi_write(input int slot, input int r, input logic [7:0] d);
        @(negedge clk);
        pi_drive(slot, r, d);
        @(negedge clk);
        pi_idle();
    endtask

    task automatic pi_expect(input int slot, input int r, input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.pi_addr  = 8'((slot << 3) | r);
        bus.pi_ce_cc = 1'b1;
        bus.pi_act   = 1'b1;
        bus.pi_we    = 1'b0;
        @(negedge clk);
        check(tag, {8'h00, pi_do}, {8'h00, exp});
        pi_idle();
    endtask

    task automatic slot_cfg(input int slot, input logic [15:0] a, input logic [7:0] repl,
                            input logic [7:0] ctrl);
        pi_write(slot, 0, a[7:0]);
        pi_write(slot, 1, a[15:8]);
        pi_write(slot, 3, repl);
        pi_write(slot, 5, ctrl);
    endtask

    // One CPU read held for 8 edges; optionally a pi write lands on edge wr_edge.
    task automatic cpu_read(input logic [15:0] a, input logic [7:0] prg, input logic exp_hit,
                            input logic [7:0] exp_do, input int wr_edge, input int wr_slot,
                            input int wr_reg, input logic [7:0] wr_data, input string tag);
        logic [7:0] want;
        want = exp_hit ? exp_do : 8'h00;
        @(negedge clk);
        bus.cpu_addr = a;
        prg_do       = prg;
        bus.cpu_rw   = 1'b1;
        bus.cpu_m2   = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == wr_edge - 1) pi_drive(wr_slot, wr_reg, wr_data);
            if (e == wr_edge) pi_idle();
            if (e == 4) check({tag, ":early"}, {15'b0, cc_ce}, 16'h0);
            if (e == 5) begin
                check({tag, ":ce"}, {15'b0, cc_ce}, {15'b0, exp_hit});
                check({tag, ":do"}, {8'h00, cc_do}, {8'h00, want});
            end
            if (e == 8) check({tag, ":held"}, {8'h00, cc_do}, {8'h00, want});
        end
        bus.cpu_m2 = 1'b0;
        #1 check({tag, ":m2fall"}, {15'b0, cc_ce}, 16'h0);
    endtask

    task automatic fast_read(input logic [15:0] a);
        @(negedge clk);
        bus.cpu_addr = a;
        bus.cpu_rw   = 1'b1;
        bus.cpu_m2   = 1'b1;
        repeat (SETTLE + 2) @(negedge clk);
        bus.cpu_m2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        cheats_on    = 1'b0;
        prg_do       = 8'h00;
        bus.pi_addr  = 8'h00;
        bus.pi_wdata = 8'h00;
        bus.cpu_addr = 16'h0000;
        bus.cpu_m2   = 1'b0;
        bus.cpu_rw   = 1'b0;
        pi_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst:ce", {15'b0, cc_ce}, 16'h0);
        check("rst:do", {8'h00, cc_do}, 16'h0);
        pi_expect(0, 5, 8'h00, "rst:ctrl0");

        // Basic override and a near-miss address
        cheats_on = 1'b1;
        slot_cfg(0, 16'hC123, 8'hEA, 8'h01);
        cpu_read(16'hC123, 8'h00, 1'b1, 8'hEA, 0, 0, 0, 8'h00, "t1");
        pi_expect(0, 7, 8'h01, "t1:hits");
        cpu_read(16'hC124, 8'h00, 1'b0, 8'h00, 0, 0, 0, 8'h00, "t1miss");

        // Global disable: nothing latched or counted
        cheats_on = 1'b0;
        cpu_read(16'hC123, 8'h00, 1'b0, 8'h00, 0, 0, 0, 8'h00, "off");
        cheats_on = 1'b1;
        pi_expect(0, 7, 8'h01, "off:hits");

        // Replacement rewritten mid-hold only shows on the following read
        cpu_read(16'hC123, 8'h00, 1'b1, 8'hEA, 6, 0, 3, 8'h99, "hold");
        cpu_read(16'hC123, 8'h00, 1'b1, 8'h99, 0, 0, 0, 8'h00, "newval");
        pi_expect(0, 7, 8'h03, "newval:hits");

        // Masked compare: A0 matches A5 in the high nibble, B5 does not
        pi_write(1, 2, 8'hA5);
        pi_write(1, 4, 8'hF0);
        slot_cfg(1, 16'h9000, 8'h55, 8'h03);
        cpu_read(16'h9000, 8'hA0, 1'b1, 8'h55, 0, 0, 0, 8'h00, "cmp_hit");
        pi_expect(1, 7, 8'h01, "cmp_hit:hits");
        cpu_read(16'h9000, 8'hB5, 1'b0, 8'h00, 0, 0, 0, 8'h00, "cmp_miss");
        pi_expect(1, 7, 8'h01, "cmp_miss:hits");
        pi_write(2, 5, 8'hFE);
        pi_expect(2, 5, 8'h02, "ctrl_bits");

        // Priority: lowest index wins, only it counts
        slot_cfg(3, 16'h8000, 8'h11, 8'h01);
        slot_cfg(7, 16'h8000, 8'h22, 8'h01);
        cpu_read(16'h8000, 8'h00, 1'b1, 8'h11, 0, 0, 0, 8'h00, "prio");
        pi_expect(3, 7, 8'h01, "prio:hits3");
        pi_expect(7, 7, 8'h00, "prio:hits7");

        // Hit limit of 2
        pi_write(4, 6, 8'h02);
        slot_cfg(4, 16'hA000, 8'h44, 8'h01);
        cpu_read(16'hA000, 8'h00, 1'b1, 8'h44, 0, 0, 0, 8'h00, "lim1");
        cpu_read(16'hA000, 8'h00, 1'b1, 8'h44, 0, 0, 0, 8'h00, "lim2");
        cpu_read(16'hA000, 8'h00, 1'b0, 8'h00, 0, 0, 0, 8'h00, "lim3");
        pi_expect(4, 5, 8'h00, "lim:ctrl");
        pi_expect(4, 7, 8'h02, "lim:hits");

        // Saturation, then a hits write racing the sample edge
        slot_cfg(5, 16'hB000, 8'h5B, 8'h01);
        repeat (300) fast_read(16'hB000);
        pi_expect(5, 7, 8'hFF, "sat:hits");
        cpu_read(16'hB000, 8'h00, 1'b1, 8'h5B, 5, 5, 7, 8'h77, "hitclr");
        pi_expect(5, 7, 8'h00, "hitclr:hits");

        // ctrl write racing auto-disable keeps the slot enabled
        pi_write(6, 6, 8'h01);
        slot_cfg(6, 16'hD000, 8'h66, 8'h01);
        cpu_read(16'hD000, 8'h00, 1'b1, 8'h66, 5, 6, 5, 8'h01, "ctrlrace");
        pi_expect(6, 5, 8'h01, "ctrlrace:ctrl");
        pi_expect(6, 7, 8'h01, "ctrlrace:hits");
        cpu_read(16'hD000, 8'h00, 1'b1, 8'h66, 0, 0, 0, 8'h00, "lastuse");
        pi_expect(6, 5, 8'h00, "lastuse:ctrl");
        cpu_read(16'hD000, 8'h00, 1'b0, 8'h00, 0, 0, 0, 8'h00, "spent");

        // Reset in the middle of an active override
        @(negedge clk);
        bus.cpu_addr = 16'hC123;
        bus.cpu_rw   = 1'b1;
        bus.cpu_m2   = 1'b1;
        repeat (5) @(negedge clk);
        check("mid:ce", {15'b0, cc_ce}, 16'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst:ce", {15'b0, cc_ce}, 16'h0);
        check("mid_rst:do", {8'h00, cc_do}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("inflight:ce", {15'b0, cc_ce}, 16'h0);
        bus.cpu_m2 = 1'b0;
        for (int r = 0; r < 8; r++) pi_expect(0, r, 8'h00, $sformatf("rst:reg%0d", r));
        pi_expect(7, 3, 8'h00, "rst:repl7");

        // Out-of-range slot writes are dropped, not aliased
        pi_write(9, 0, 8'h5A);
        pi_expect(1, 0, 8'h00, "oor:alias");
        pi_expect(9, 0, 8'h00, "oor:read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
